// File: rtl/aes_round_ctrl_if.sv
// Bundle of handshake, block data and round-datapath signals shared between
// the AES-128 round sequencer and the logic around it. The sequencer takes the
// slave view; whoever supplies blocks and the round datapath takes the master view.
interface aes_round_ctrl_if;
  // Upstream handshake and block data
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;

  // Downstream handshake and result
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;

  // Towards the external round datapath and key-expansion step
  logic [127:0] state_q;
  logic [127:0] round_key_q;
  logic [7:0]   rcon;
  logic [3:0]   round_num;
  logic         skip_mix;

  // Back from the external round datapath and key-expansion step
  logic [127:0] dp_state;
  logic [127:0] dp_key;

  // Status
  logic         busy;

  modport slave (
    input  in_valid, plaintext, key, out_ready, dp_state, dp_key,
    output in_ready, out_valid, ciphertext, state_q, round_key_q,
           rcon, round_num, skip_mix, busy
  );

  modport master (
    output in_valid, plaintext, key, out_ready, dp_state, dp_key,
    input  in_ready, out_valid, ciphertext, state_q, round_key_q,
           rcon, round_num, skip_mix, busy
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption round sequencer.
// Holds the 128-bit state and round key, performs the initial key add on
// accept and the per-round key add on every round, and steps an external
// combinational round datapath (SubBytes/ShiftRows/MixColumns) plus the
// key-expansion step one round per clock. One block is in flight at a time;
// a result waiting in DONE can be handed off in the same cycle a new block
// is accepted.
module aes_round_ctrl #(
  parameter int         NUM_ROUNDS = 10,
  parameter logic [7:0] RCON_INIT  = 8'h01
) (
  input logic             clk,
  input logic             rst,
  aes_round_ctrl_if.slave bus
);

  // Sequencer states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Final round number; the counter holds here while the result waits
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [3:0] FIRST_ROUND = 4'd1;
  localparam logic [3:0] NO_ROUND = 4'd0;

  // Doubling in GF(2^8) modulo x^8+x^4+x^3+x+1; advances the round constant
  function automatic logic [7:0] xtime(input logic [7:0] r);
    xtime = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // Registered state
  logic [1:0]   fsm;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [7:0]   rcon_reg;
  logic [3:0]   round_reg;
  logic         out_valid_reg;
  logic         skip_mix_reg;
  logic         busy_reg;

  // Next-state values
  logic [1:0]   fsm_nxt;
  logic [127:0] state_nxt;
  logic [127:0] key_nxt;
  logic [7:0]   rcon_nxt;
  logic [3:0]   round_nxt;

  // Handshake decode
  logic ready;
  logic accept;
  logic last_round;
  logic result_taken;

  // A new block can enter when idle, or when the waiting result leaves this cycle
  assign ready        = (fsm == IDLE) || ((fsm == DONE) && bus.out_ready);
  assign accept       = bus.in_valid && ready;
  assign last_round   = (round_reg == LAST_ROUND);
  assign result_taken = (fsm == DONE) && bus.out_ready;

  // Next-state and datapath-load selection for the round sequencer
  always_comb begin
    fsm_nxt   = fsm;
    state_nxt = state_reg;
    key_nxt   = key_reg;
    rcon_nxt  = rcon_reg;
    round_nxt = round_reg;

    case (fsm)
      IDLE: begin
        if (accept) begin
          // Initial AddRoundKey happens on capture
          state_nxt = bus.plaintext ^ bus.key;
          key_nxt   = bus.key;
          round_nxt = FIRST_ROUND;
          rcon_nxt  = RCON_INIT;
          fsm_nxt   = ROUND;
        end else begin
          round_nxt = NO_ROUND;
          rcon_nxt  = RCON_INIT;
          fsm_nxt   = IDLE;
        end
      end

      ROUND: begin
        // Datapath result plus this round's key add; in_valid is ignored here
        state_nxt = bus.dp_state ^ bus.dp_key;
        key_nxt   = bus.dp_key;
        if (last_round) begin
          // Counter holds at the last round; rcon parks at its idle value
          round_nxt = round_reg;
          rcon_nxt  = RCON_INIT;
          fsm_nxt   = DONE;
        end else begin
          round_nxt = round_reg + 4'd1;
          rcon_nxt  = xtime(rcon_reg);
          fsm_nxt   = ROUND;
        end
      end

      DONE: begin
        if (accept) begin
          // Result leaves and the next block loads in the same cycle
          state_nxt = bus.plaintext ^ bus.key;
          key_nxt   = bus.key;
          round_nxt = FIRST_ROUND;
          rcon_nxt  = RCON_INIT;
          fsm_nxt   = ROUND;
        end else if (result_taken) begin
          round_nxt = NO_ROUND;
          rcon_nxt  = RCON_INIT;
          fsm_nxt   = IDLE;
        end else begin
          // Backpressure: everything holds, result stays on ciphertext
          fsm_nxt = DONE;
        end
      end

      default: begin
        // Unreachable encoding: drop any partial block and return to idle
        state_nxt = 128'h0;
        key_nxt   = 128'h0;
        round_nxt = NO_ROUND;
        rcon_nxt  = RCON_INIT;
        fsm_nxt   = IDLE;
      end
    endcase
  end

  // Sequencer registers; reset aborts any block in flight with no output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm           <= IDLE;
      state_reg     <= 128'h0;
      key_reg       <= 128'h0;
      rcon_reg      <= RCON_INIT;
      round_reg     <= NO_ROUND;
      out_valid_reg <= 1'b0;
      skip_mix_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      fsm           <= fsm_nxt;
      state_reg     <= state_nxt;
      key_reg       <= key_nxt;
      rcon_reg      <= rcon_nxt;
      round_reg     <= round_nxt;
      out_valid_reg <= (fsm_nxt == DONE);
      skip_mix_reg  <= (round_nxt == LAST_ROUND);
      busy_reg      <= (fsm_nxt != IDLE);
    end
  end

  // Outputs come straight from registers, except the combinational in_ready
  assign bus.in_ready    = ready;
  assign bus.out_valid   = out_valid_reg;
  assign bus.ciphertext  = state_reg;
  assign bus.state_q     = state_reg;
  assign bus.round_key_q = key_reg;
  assign bus.rcon        = rcon_reg;
  assign bus.round_num   = round_reg;
  assign bus.skip_mix    = skip_mix_reg;
  assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl. The bench supplies the round
// datapath and key expansion, keeps a whole-cipher reference model, queues the
// expected ciphertext on each accept and lets a monitor compare results as
// they are handed off.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst;

  aes_round_ctrl_if bus ();

  aes_round_ctrl #(.NUM_ROUNDS(10), .RCON_INIT(8'h01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [127:0] sb_q[$];
  logic [127:0] mon_exp;
  logic [7:0]   rcon_tab [1:10];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ST_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- GF(2^8) and AES reference functions ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i != 0) r = gmul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // SubBytes, ShiftRows and (unless last) MixColumns on a column-major state
  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] c0, c1, c2, c3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int col = 0; col < 4; col++)
      for (int rw = 0; rw < 4; rw++)
        b[rw + 4*col] = a[rw + 4*((col + rw) % 4)];
    if (!last) begin
      for (int col = 0; col < 4; col++) begin
        c0 = b[4*col]; c1 = b[4*col+1]; c2 = b[4*col+2]; c3 = b[4*col+3];
        b[4*col]   = gmul(c0, 8'h02) ^ gmul(c1, 8'h03) ^ c2 ^ c3;
        b[4*col+1] = c0 ^ gmul(c1, 8'h02) ^ gmul(c2, 8'h03) ^ c3;
        b[4*col+2] = c0 ^ c1 ^ gmul(c2, 8'h02) ^ gmul(c3, 8'h03);
        b[4*col+3] = gmul(c0, 8'h03) ^ c1 ^ c2 ^ gmul(c3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Whole AES-128 encryption, used to predict every result
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] s  = pt ^ k;
    logic [127:0] rk = k;
    logic [7:0]   rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk = next_key(rk, rc);
      s  = round_fn(s, r == 10) ^ rk;
      rc = gmul(rc, 8'h02);
    end
    return s;
  endfunction

  // External round datapath and key-expansion step seen by the sequencer
  always_comb begin
    bus.dp_state = round_fn(bus.state_q, bus.skip_mix);
    bus.dp_key   = next_key(bus.round_key_q, bus.rcon);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handed-off result is compared with the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got ciphertext %h expected no output", bus.ciphertext);
      end else begin
        mon_exp = sb_q.pop_front();
        check("sb_ciphertext", bus.ciphertext, mon_exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready(input bit rand_or);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      if (rand_or) bus.out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 100 cycles");
    end
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got out_valid 0 expected 1 within 40 cycles");
    end
  endtask

  // Present one block, queue its expected result and complete the accept edge
  task automatic send(input logic [127:0] pt, input logic [127:0] k,
                      input logic [127:0] exp_ct, input bit rand_or);
    wait_in_ready(rand_or);
    bus.plaintext = pt;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    sb_q.push_back(exp_ct);
    step();
    bus.in_valid  = 1'b0;
    bus.plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.key       = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Hard stop in case anything hangs
  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] pt, k;
    int n;
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = 128'h0;
    bus.key       = 128'h0;
    rst = 1'b1;
    step();
    step();

    // Reset state
    check("rst_in_ready",    128'(bus.in_ready),    128'd1);
    check("rst_out_valid",   128'(bus.out_valid),   128'd0);
    check("rst_state_q",     bus.state_q,           128'h0);
    check("rst_round_key_q", bus.round_key_q,       128'h0);
    check("rst_round_num",   128'(bus.round_num),   128'd0);
    check("rst_rcon",        128'(bus.rcon),        128'h01);
    check("rst_skip_mix",    128'(bus.skip_mix),    128'd0);
    check("rst_busy",        128'(bus.busy),        128'd0);
    rst = 1'b0;
    step();

    // FIPS-197 App. B with per-round rcon/skip_mix/latency checks
    bus.out_ready = 1'b1;
    send(PT_B, KEY_B, CT_B, 1'b0);
    check("b_state_after_accept", bus.state_q, ST_B);
    check("b_key_after_accept",   bus.round_key_q, KEY_B);
    for (int r = 1; r <= 10; r++) begin
      check("b_round_num", 128'(bus.round_num), 128'(r));
      check("b_rcon",      128'(bus.rcon),      128'(rcon_tab[r]));
      check("b_skip_mix",  128'(bus.skip_mix),  128'(r == 10));
      check("b_out_valid_early", 128'(bus.out_valid), 128'd0);
      check("b_busy",      128'(bus.busy),      128'd1);
      check("b_in_ready_round", 128'(bus.in_ready), 128'd0);
      step();
    end
    check("b_out_valid_latency", 128'(bus.out_valid), 128'd1);
    check("b_ciphertext",  bus.ciphertext, CT_B);
    check("b_rcon_done",   128'(bus.rcon), 128'h01);
    step();
    check("b_idle_out_valid", 128'(bus.out_valid), 128'd0);
    check("b_idle_round_num", 128'(bus.round_num), 128'd0);
    check("b_idle_in_ready",  128'(bus.in_ready),  128'd1);

    // App. C.1 under backpressure, then back-to-back accept of App. B
    bus.out_ready = 1'b0;
    send(PT_C, KEY_C, CT_C, 1'b0);
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid",  128'(bus.out_valid), 128'd1);
      check("bp_ciphertext", bus.ciphertext, CT_C);
      check("bp_in_ready",   128'(bus.in_ready), 128'd0);
      step();
    end
    bus.out_ready = 1'b1;
    bus.plaintext = PT_B;
    bus.key       = KEY_B;
    bus.in_valid  = 1'b1;
    #1;
    check("b2b_in_ready", 128'(bus.in_ready), 128'd1);
    sb_q.push_back(CT_B);
    step();
    bus.in_valid = 1'b0;
    check("b2b_round_num", 128'(bus.round_num), 128'd1);
    check("b2b_state_q",   bus.state_q, ST_B);
    check("b2b_out_valid", 128'(bus.out_valid), 128'd0);
    wait_out_valid();
    step();

    // Reset in round 5 aborts the block; App. C.1 follows cleanly
    send(PT_B, KEY_B, CT_B, 1'b0);
    n = 0;
    while (bus.round_num != 4'd5 && n < 20) begin
      step();
      n++;
    end
    check("abort_round5", 128'(bus.round_num), 128'd5);
    rst = 1'b1;
    #1;
    sb_q.delete();
    check("abort_round_num", 128'(bus.round_num), 128'd0);
    check("abort_out_valid", 128'(bus.out_valid), 128'd0);
    check("abort_in_ready",  128'(bus.in_ready),  128'd1);
    check("abort_busy",      128'(bus.busy),      128'd0);
    step();
    check("abort_idle_out_valid", 128'(bus.out_valid), 128'd0);
    rst = 1'b0;
    step();
    send(PT_C, KEY_C, CT_C, 1'b0);
    wait_out_valid();
    step();

    // in_valid pulsed mid-block with a different block is ignored
    send(PT_B, KEY_B, CT_B, 1'b0);
    step();
    step();
    bus.plaintext = PT_C;
    bus.key       = KEY_C;
    bus.in_valid  = 1'b1;
    #1;
    check("ign_in_ready", 128'(bus.in_ready), 128'd0);
    step();
    bus.in_valid = 1'b0;
    check("ign_round_num", 128'(bus.round_num), 128'd4);
    wait_out_valid();
    step();

    // Random blocks with random gaps and random downstream backpressure
    for (int b = 0; b < 12; b++) begin
      repeat ($urandom_range(0, 3)) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        step();
      end
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      k  = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(pt, k, aes_ref(pt, k), 1'b1);
    end
    bus.out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    step();
    check("sb_drained", 128'(sb_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
